// File: rtl/order_tx_scheduler_if.sv
// Order link bundle: two requester push ports with full/overflow status,
// plus the serial link outputs (ser_en, ser_data) and grant/busy/sent status.
interface order_tx_scheduler_if #(
   parameter int DATA_W = 32
);
   logic              req0_valid;
   logic [DATA_W-1:0] req0_data;
   logic              req0_full;
   logic              req0_ovf;
   logic              req1_valid;
   logic [DATA_W-1:0] req1_data;
   logic              req1_full;
   logic              req1_ovf;
   logic              ser_en;
   logic              ser_data;
   logic              grant_id;
   logic              busy;
   logic              sent;

   modport master (
      output req0_valid, req0_data,
      output req1_valid, req1_data,
      input  req0_full, req0_ovf,
      input  req1_full, req1_ovf,
      input  ser_en, ser_data,
      input  grant_id, busy, sent
   );

   modport slave (
      input  req0_valid, req0_data,
      input  req1_valid, req1_data,
      output req0_full, req0_ovf,
      output req1_full, req1_ovf,
      output ser_en, ser_data,
      output grant_id, busy, sent
   );
endinterface

// File: rtl/order_tx_scheduler.sv
// Two-requester order link scheduler: per-source FIFOs, round-robin grant,
// MSB-first serial framing with an inter-frame gap.
// Ports: clk, CPU_RESETN (async, active low), ord (slave side of the link bundle).
module order_tx_scheduler #(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int BIT_DIV    = 1,
   parameter int GAP        = 2
) (
   input logic                 clk,
   input logic                 CPU_RESETN,
   order_tx_scheduler_if.slave ord
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
   localparam int BW = $clog2(DATA_W);
   localparam int GT = GAP * BIT_DIV;
   localparam int GW = (GT > 1) ? $clog2(GT) : 1;

   localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
   localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);
   localparam logic [DW-1:0] DIV_PEN  = DW'(BIT_DIV - 2);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
   localparam logic [BW-1:0] BIT_PEN  = BW'(DATA_W - 2);
   localparam logic [GW-1:0] GAP_LAST = GW'(GT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_GAP
   } state_t;

   state_t            state;
   logic              last_grant;
   logic              grant_q;
   logic              busy_q;
   logic              en_q;
   logic              data_q;
   logic              sent_q;
   logic [DATA_W-1:0] shreg;
   logic [DW-1:0]     div_cnt;
   logic [BW-1:0]     bit_cnt;
   logic [GW-1:0]     gap_cnt;

   logic [1:0]        push_req;
   logic [1:0]        full;
   logic [1:0]        ovf;
   logic [1:0]        nonempty;
   logic [1:0]        pop;
   logic [DATA_W-1:0] push_data [2];
   logic [DATA_W-1:0] head [2];
   logic              pick;
   logic              last_next;

   assign push_req     = {ord.req1_valid, ord.req0_valid};
   assign push_data[0] = ord.req0_data;
   assign push_data[1] = ord.req1_data;

   assign ord.req0_full = full[0];
   assign ord.req1_full = full[1];
   assign ord.req0_ovf  = ovf[0];
   assign ord.req1_ovf  = ovf[1];
   assign ord.ser_en    = en_q;
   assign ord.ser_data  = data_q;
   assign ord.grant_id  = grant_q;
   assign ord.busy      = busy_q;
   assign ord.sent      = sent_q;

   // Only LOAD pops, and only the FIFO granted on entry to LOAD.
   assign pop = (state == S_LOAD) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;

   for (genvar g = 0; g < 2; g++) begin : g_fifo
      logic [DATA_W-1:0] mem [FIFO_DEPTH];
      logic [PW-1:0]     wp;
      logic [PW-1:0]     rp;
      logic [CW-1:0]     cnt;
      logic              ovf_q;
      logic              push;

      // full comes from the registered count, so a full FIFO rejects
      // a push even when it is popped on the same edge.
      assign full[g]     = (cnt == CNT_FULL);
      assign nonempty[g] = (cnt != '0);
      assign push        = push_req[g] & ~full[g];
      assign head[g]     = mem[rp];
      assign ovf[g]      = ovf_q;

      always_ff @(posedge clk) begin
         if (push) mem[wp] <= push_data[g];
      end

      always_ff @(posedge clk or negedge CPU_RESETN) begin
         if (!CPU_RESETN) begin
            wp    <= '0;
            rp    <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
         end else begin
            ovf_q <= push_req[g] & full[g];
            if (push) wp <= wp + PW'(1);
            if (pop[g]) rp <= rp + PW'(1);
            cnt <= cnt + CW'(push) - CW'(pop[g]);
         end
      end
   end

   // Both waiting: alternate away from the last winner.
   assign pick = (&nonempty) ? ~last_grant : nonempty[1];

   // True when the coming cycle is the final cycle of the frame.
   assign last_next = (BIT_DIV == 1) ? (bit_cnt == BIT_PEN)
                    : (bit_cnt == BIT_LAST && div_cnt == DIV_PEN);

   always_ff @(posedge clk or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state      <= S_IDLE;
         last_grant <= 1'b1;
         grant_q    <= 1'b0;
         busy_q     <= 1'b0;
         en_q       <= 1'b0;
         data_q     <= 1'b0;
         sent_q     <= 1'b0;
         shreg      <= '0;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         gap_cnt    <= '0;
      end else begin
         sent_q <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (|nonempty) begin
                  state      <= S_LOAD;
                  grant_q    <= pick;
                  last_grant <= pick;
                  busy_q     <= 1'b1;
               end
            end
            S_LOAD: begin
               shreg   <= head[grant_q];
               data_q  <= head[grant_q][DATA_W-1];
               en_q    <= 1'b1;
               div_cnt <= '0;
               bit_cnt <= '0;
               state   <= S_SHIFT;
            end
            S_SHIFT: begin
               sent_q <= last_next;
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  if (bit_cnt == BIT_LAST) begin
                     en_q    <= 1'b0;
                     data_q  <= 1'b0;
                     gap_cnt <= '0;
                     state   <= S_GAP;
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                     shreg   <= shreg << 1;
                     data_q  <= shreg[DATA_W-2];
                  end
               end else begin
                  div_cnt <= div_cnt + DW'(1);
               end
            end
            S_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state  <= S_IDLE;
                  busy_q <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_order_tx_scheduler.sv
// Scoreboard bench for order_tx_scheduler: default instance plus a
// BIT_DIV=3 instance; a monitor rebuilds frames and checks them against queued expectations.
module tb_order_tx_scheduler;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   order_tx_scheduler_if #(.DATA_W(32)) bus0 ();
   order_tx_scheduler_if #(.DATA_W(32)) bus3 ();

   order_tx_scheduler dut (
      .clk        (clk),
      .CPU_RESETN (rst_n),
      .ord        (bus0.slave)
   );

   order_tx_scheduler #(.BIT_DIV(3)) dut3 (
      .clk        (clk),
      .CPU_RESETN (rst_n),
      .ord        (bus3.slave)
   );

   typedef struct {
      logic        id;
      logic [31:0] word;
      int          gap;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   n_chk = 0;
   int   n_pass = 0;

   wire [1:0] en  = {bus3.ser_en, bus0.ser_en};
   wire [1:0] dat = {bus3.ser_data, bus0.ser_data};
   wire [1:0] snt = {bus3.sent, bus0.sent};
   wire [1:0] gid = {bus3.grant_id, bus0.grant_id};
   wire [1:0] bsy = {bus3.busy, bus0.busy};

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic expect_frame(int d, logic id, logic [31:0] w, int gap);
      exp_t e;
      e.id = id;
      e.word = w;
      e.gap = gap;
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   function automatic int qsize(int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   // Monitor state, one slot per instance.
   int          bd [2] = '{1, 3};
   int          run [2] = '{0, 0};
   int          low [2] = '{0, 0};
   int          gap_seen [2];
   logic        gid_seen [2];
   logic [31:0] acc [2];
   bit          bad [2] = '{0, 0};

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            run[d] = 0;
            low[d] = 0;
            bad[d] = 0;
         end else if (en[d]) begin
            if (run[d] == 0) begin
               gap_seen[d] = low[d];
               gid_seen[d] = gid[d];
               acc[d] = '0;
            end
            if (run[d] % bd[d] == 0) acc[d] = {acc[d][30:0], dat[d]};
            else if (dat[d] != acc[d][0]) bad[d] = 1;
            run[d]++;
            if (snt[d] != (run[d] == 32 * bd[d])) bad[d] = 1;
         end else begin
            chk($sformatf("idle_lines%0d", d), {snt[d], dat[d]}, 2'b00);
            if (run[d] != 0) begin
               exp_t e;
               if (qsize(d) == 0) begin
                  chk($sformatf("frame_expected%0d", d), 0, 1);
               end else begin
                  if (d == 0) e = q0.pop_front();
                  else e = q1.pop_front();
                  chk($sformatf("word%0d", d), acc[d], e.word);
                  chk($sformatf("grant%0d", d), gid_seen[d], e.id);
                  chk($sformatf("length%0d", d), run[d], 32 * bd[d]);
                  chk($sformatf("framing%0d", d), bad[d], 0);
                  if (e.gap >= 0) chk($sformatf("gap%0d", d), gap_seen[d], e.gap);
               end
               run[d] = 0;
               bad[d] = 0;
               low[d] = 1;
            end else begin
               low[d]++;
            end
         end
      end
   end

   task automatic push(logic v0, logic [31:0] d0, logic v1, logic [31:0] d1);
      bus0.req0_valid = v0;
      bus0.req0_data  = d0;
      bus0.req1_valid = v1;
      bus0.req1_data  = d1;
      @(posedge clk);
      #1;
      bus0.req0_valid = 1'b0;
      bus0.req1_valid = 1'b0;
   endtask

   task automatic wait_idle(int d, string tag);
      int n = 0;
      while (n < 3000) begin
         @(posedge clk);
         #1;
         n++;
         if (qsize(d) == 0 && bsy[d] == 1'b0) break;
      end
      chk({"idle_timeout_", tag}, n < 3000, 1);
   endtask

   task automatic wait_en(int d, string tag);
      int n = 0;
      while (n < 100 && en[d] == 1'b0) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({"start_timeout_", tag}, n < 100, 1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] r [5];
      r[0] = 32'h11110000;
      r[1] = 32'h22220001;
      r[2] = 32'h33330002;
      r[3] = 32'h44440003;
      r[4] = 32'h55550004;

      bus0.req0_valid = 1'b0;
      bus0.req0_data  = '0;
      bus0.req1_valid = 1'b0;
      bus0.req1_data  = '0;
      bus3.req0_valid = 1'b0;
      bus3.req0_data  = '0;
      bus3.req1_valid = 1'b0;
      bus3.req1_data  = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ser_en", en[0], 0);
      chk("rst_ser_data", dat[0], 0);
      chk("rst_sent", snt[0], 0);
      chk("rst_busy", bsy[0], 0);
      chk("rst_grant", gid[0], 0);
      chk("rst_full", {bus0.req1_full, bus0.req0_full}, 0);
      chk("rst_ovf", {bus0.req1_ovf, bus0.req0_ovf}, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single frame and its start latency.
      expect_frame(0, 1'b0, 32'hA5A50001, -1);
      push(1'b1, 32'hA5A50001, 1'b0, '0);
      chk("lat_e0_en", en[0], 0);
      @(posedge clk);
      #1;
      chk("lat_e1_busy", bsy[0], 1);
      chk("lat_e1_en", en[0], 0);
      @(posedge clk);
      #1;
      chk("lat_e2_en", en[0], 1);
      chk("lat_e2_msb", dat[0], 1);
      wait_idle(0, "single");

      // Simultaneous pushes right after reset: req0 wins the tie.
      do_reset();
      expect_frame(0, 1'b0, 32'hC0DE0000, -1);
      expect_frame(0, 1'b1, 32'hC0DE0001, 4);
      push(1'b1, 32'hC0DE0000, 1'b1, 32'hC0DE0001);
      wait_idle(0, "tie");

      // Two words in each FIFO: strict alternation with minimum gaps.
      expect_frame(0, 1'b0, 32'h0A000001, -1);
      expect_frame(0, 1'b1, 32'h0B000001, 4);
      expect_frame(0, 1'b0, 32'h0A000002, 4);
      expect_frame(0, 1'b1, 32'h0B000002, 4);
      push(1'b1, 32'h0A000001, 1'b1, 32'h0B000001);
      push(1'b1, 32'h0A000002, 1'b1, 32'h0B000002);
      wait_idle(0, "rr");

      // Overfill FIFO 0 while a req1 frame shifts.
      expect_frame(0, 1'b1, 32'hFEEDBEEF, -1);
      push(1'b0, '0, 1'b1, 32'hFEEDBEEF);
      wait_en(0, "ovf");
      for (int i = 0; i < 4; i++) expect_frame(0, 1'b0, r[i], 4);
      for (int i = 0; i < 5; i++) begin
         bus0.req0_valid = 1'b1;
         bus0.req0_data  = r[i];
         @(posedge clk);
         #1;
         if (i == 3) begin
            chk("full_after_4", bus0.req0_full, 1);
            chk("no_ovf_at_4", bus0.req0_ovf, 0);
         end
         if (i == 4) chk("ovf_pulse", bus0.req0_ovf, 1);
      end
      bus0.req0_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("ovf_single", bus0.req0_ovf, 0);
      wait_idle(0, "ovf");

      // Reset during bit 10 with two words still queued.
      push(1'b1, 32'hDEAD0001, 1'b0, '0);
      push(1'b1, 32'hDEAD0002, 1'b0, '0);
      push(1'b1, 32'hDEAD0003, 1'b0, '0);
      wait_en(0, "abort");
      repeat (9) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_en_drop", en[0], 0);
      chk("async_data_drop", dat[0], 0);
      chk("async_busy_drop", bsy[0], 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (60) @(posedge clk);
      #1;
      chk("post_rst_busy", bsy[0], 0);
      chk("post_rst_full", bus0.req0_full, 0);
      expect_frame(0, 1'b1, 32'h600D0001, -1);
      push(1'b0, '0, 1'b1, 32'h600D0001);
      wait_idle(0, "after_rst");

      // Slow bit rate instance.
      expect_frame(1, 1'b1, 32'h80000000, -1);
      bus3.req1_valid = 1'b1;
      bus3.req1_data  = 32'h80000000;
      @(posedge clk);
      #1;
      bus3.req1_valid = 1'b0;
      wait_idle(1, "div3");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
